// File: rtl/s526_resp_misr.sv
// Response MISR for the s526n core: compacts RESP over a LEN-sample window and
// compares the signature to EXPECT. Define S526_MISR_XMASK_EN to add the XMASK port.
module s526_resp_misr #(
  parameter int               WIDTH = 6,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'('h03)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] LEN,
  input  logic [WIDTH-1:0] SEED,
  input  logic [WIDTH-1:0] EXPECT,
  input  logic [WIDTH-1:0] RESP,
`ifdef S526_MISR_XMASK_EN
  input  logic [WIDTH-1:0] XMASK,
`endif
  output logic [WIDTH-1:0] SIG,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [WIDTH-1:0] exp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pass_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] resp_eff;

  always_comb begin
`ifdef S526_MISR_XMASK_EN
    resp_eff = RESP & ~XMASK;
`else
    resp_eff = RESP;
`endif
    sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp_eff;
  end

  // IDLE and DONE accept START identically, which gives back-to-back restarts.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sig_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ABORT) begin
            state_q <= ST_IDLE;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            sig_q <= sig_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_DONE;
              pass_q  <= (sig_d == exp_q);
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          if (START) begin
            sig_q <= SEED;
            cnt_q <= LEN;
            exp_q <= EXPECT;
            if (LEN == '0) begin
              state_q <= ST_DONE;
              pass_q  <= (SEED == EXPECT);
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              pass_q  <= 1'b0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign SIG  = sig_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign PASS = pass_q;

endmodule

// File: tb/tb_s526_resp_misr.sv
// Bench for s526_resp_misr: directed scenarios plus random traffic, checked every
// cycle against a polynomial-arithmetic model of the signature and capture window.
module tb_s526_resp_misr;
  localparam int          W  = 6;
  localparam int          CW = 16;
  localparam logic [W-1:0] P = 6'h03;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [CW-1:0] LEN = '0;
  logic [W-1:0]  SEED = '0;
  logic [W-1:0]  EXPECT = '0;
  logic [W-1:0]  RESP = '0;
`ifdef S526_MISR_XMASK_EN
  logic [W-1:0]  XMASK = '0;
`endif
  logic [W-1:0]  SIG;
  logic          BUSY;
  logic          DONE;
  logic          PASS;

  always #5 CK = ~CK;

  s526_resp_misr #(.WIDTH(W), .CNT_W(CW), .POLY(P)) dut (
    .CK(CK),
    .RST(RST),
    .START(START),
    .ABORT(ABORT),
    .LEN(LEN),
    .SEED(SEED),
    .EXPECT(EXPECT),
    .RESP(RESP),
`ifdef S526_MISR_XMASK_EN
    .XMASK(XMASK),
`endif
    .SIG(SIG),
    .BUSY(BUSY),
    .DONE(DONE),
    .PASS(PASS)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signature times x modulo x^W + POLY, then add the response word.
  function automatic logic [W-1:0] mstep(input logic [W-1:0] s, input logic [W-1:0] r);
    int v;
    v = int'(s) * 2;
    if (v >= (1 << W)) v = v ^ ((1 << W) | int'(P));
    return W'(v) ^ r;
  endfunction

  function automatic logic [W-1:0] reff();
`ifdef S526_MISR_XMASK_EN
    return RESP & ~XMASK;
`else
    return RESP;
`endif
  endfunction

  // Model: phase 0 idle, 1 capturing, 2 done.
  int           m_phase;
  int           m_left;
  logic [W-1:0] m_sig;
  logic [W-1:0] m_exp;
  logic         m_pass;

  always @(posedge CK or posedge RST) begin
    if (RST) begin
      m_phase <= 0;
      m_left  <= 0;
      m_sig   <= '0;
      m_exp   <= '0;
      m_pass  <= 1'b0;
    end else if (m_phase == 1) begin
      if (ABORT) begin
        m_phase <= 0;
        m_pass  <= 1'b0;
      end else begin
        m_sig  <= mstep(m_sig, reff());
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_phase <= 2;
          m_pass  <= (mstep(m_sig, reff()) == m_exp);
        end
      end
    end else if (START) begin
      m_sig  <= SEED;
      m_exp  <= EXPECT;
      m_left <= int'(LEN);
      if (LEN == '0) begin
        m_phase <= 2;
        m_pass  <= (SEED == EXPECT);
      end else begin
        m_phase <= 1;
        m_pass  <= 1'b0;
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge CK) begin
    if (chk_en && !RST) begin
      check("sig_model", 32'(SIG), 32'(m_sig));
      check("busy_model", 32'(BUSY), 32'(m_phase == 1));
      check("done_model", 32'(DONE), 32'(m_phase == 2));
      check("pass_model", 32'(PASS), 32'(m_pass));
    end
  end

  task automatic cyc();
    @(posedge CK);
    #1;
  endtask

  task automatic start(input logic [CW-1:0] l, input logic [W-1:0] s, input logic [W-1:0] e);
    START = 1'b1;
    LEN = l;
    SEED = s;
    EXPECT = e;
    cyc();
    START = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r[4];
    logic [W-1:0] acc;
    logic [W-1:0] sd;
    logic [W-1:0] rv;

    #2;
    check("rst_sig", 32'(SIG), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_pass", 32'(PASS), 0);
    #10;
    RST = 1'b0;
    chk_en = 1'b1;

    // Single sample, matching and mismatching golden value
    RESP = 6'h2A;
    start(16'd1, 6'h00, 6'h2A);
    check("t1_busy", 32'(BUSY), 1);
    cyc();
    check("t1_sig", 32'(SIG), 32'h2A);
    check("t1_done", 32'(DONE), 1);
    check("t1_pass", 32'(PASS), 1);
    cyc();
    check("t1_done_low", 32'(DONE), 0);
    check("t1_pass_hold", 32'(PASS), 1);
    start(16'd1, 6'h00, 6'h2B);
    cyc();
    check("t1b_sig", 32'(SIG), 32'h2A);
    check("t1b_pass", 32'(PASS), 0);
    cyc();

    // Feedback taps when the MSB shifts out
    RESP = 6'h20;
    start(16'd2, 6'h00, 6'h03);
    cyc();
    check("t2_sig1", 32'(SIG), 32'h20);
    check("t2_busy1", 32'(BUSY), 1);
    RESP = 6'h00;
    cyc();
    check("t2_sig2", 32'(SIG), 32'h03);
    check("t2_done", 32'(DONE), 1);
    check("t2_busy2", 32'(BUSY), 0);
    check("t2_pass", 32'(PASS), 1);
    cyc();
    check("t2_done_low", 32'(DONE), 0);

    // Zero-length capture
    start(16'd0, 6'h15, 6'h15);
    check("t3_done", 32'(DONE), 1);
    check("t3_sig", 32'(SIG), 32'h15);
    check("t3_pass", 32'(PASS), 1);
    check("t3_busy", 32'(BUSY), 0);
    cyc();
    check("t3_done_low", 32'(DONE), 0);

    // Abort on the 4th capture cycle; START mid-capture is ignored
    for (int i = 0; i < 4; i++) r[i] = W'($urandom);
    sd = W'($urandom);
    start(16'd10, sd, 6'h00);
    RESP = r[0];
    cyc();
    RESP = r[1];
    cyc();
    RESP = r[2];
    START = 1'b1;
    LEN = 16'd0;
    cyc();
    START = 1'b0;
    ABORT = 1'b1;
    RESP = r[3];
    cyc();
    ABORT = 1'b0;
    acc = mstep(mstep(mstep(sd, r[0]), r[1]), r[2]);
    check("t4_busy", 32'(BUSY), 0);
    check("t4_done", 32'(DONE), 0);
    check("t4_pass", 32'(PASS), 0);
    check("t4_sig", 32'(SIG), 32'(acc));
    cyc();
    check("t4_done_after", 32'(DONE), 0);
    check("t4_sig_frozen", 32'(SIG), 32'(acc));

    // Asynchronous reset mid-capture, then a clean LEN=3 capture
    RESP = W'($urandom);
    start(16'd5, W'($urandom), 6'h00);
    cyc();
    #3;
    RST = 1'b1;
    #1;
    check("t5_rst_sig", 32'(SIG), 0);
    check("t5_rst_busy", 32'(BUSY), 0);
    check("t5_rst_done", 32'(DONE), 0);
    check("t5_rst_pass", 32'(PASS), 0);
    #2;
    RST = 1'b0;
    cyc();
    sd = W'($urandom);
    rv = W'($urandom);
    RESP = rv;
    acc = mstep(mstep(mstep(sd, rv), rv), rv);
    start(16'd3, sd, acc);
    cyc();
    cyc();
    cyc();
    check("t5_done", 32'(DONE), 1);
    check("t5_pass", 32'(PASS), 1);
    check("t5_sig", 32'(SIG), 32'(acc));
    cyc();

    // Eight random samples, fully masked when the mask port exists
`ifdef S526_MISR_XMASK_EN
    XMASK = 6'h3F;
`endif
    acc = '0;
    start(16'd8, 6'h00, 6'h00);
    for (int i = 0; i < 8; i++) begin
      RESP = W'($urandom);
`ifdef S526_MISR_XMASK_EN
      acc = mstep(acc, 6'h00);
`else
      acc = mstep(acc, RESP);
`endif
      cyc();
    end
    check("t6_done", 32'(DONE), 1);
    check("t6_sig", 32'(SIG), 32'(acc));
`ifdef S526_MISR_XMASK_EN
    check("t6_masked_zero", 32'(SIG), 0);
    XMASK = '0;
`endif
    cyc();

    // Restart from the DONE cycle with no idle gap
    start(16'd2, W'($urandom), W'($urandom));
    cyc();
    cyc();
    check("t7_done", 32'(DONE), 1);
    start(16'd3, W'($urandom), W'($urandom));
    check("t7_busy_again", 32'(BUSY), 1);
    cyc();
    cyc();
    cyc();
    check("t7_done2", 32'(DONE), 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      START  = ($urandom % 4) == 0;
      ABORT  = ($urandom % 10) == 0;
      LEN    = CW'($urandom % 7);
      SEED   = W'($urandom);
      EXPECT = W'($urandom % 4);
      RESP   = W'($urandom);
`ifdef S526_MISR_XMASK_EN
      XMASK  = W'($urandom);
`endif
      cyc();
    end
    START = 1'b0;
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    cyc();

    // Longest capture the counter allows
    start(16'hFFFF, W'($urandom), W'($urandom));
    for (int i = 0; i < 65534; i++) begin
      RESP = W'($urandom);
      cyc();
    end
    check("t9_busy_last", 32'(BUSY), 1);
    RESP = W'($urandom);
    cyc();
    check("t9_done", 32'(DONE), 1);
    check("t9_busy_end", 32'(BUSY), 0);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s526_resp_misr.md
# s526_resp_misr

Multiple-input signature register (MISR) that compacts the per-cycle primary-output response of the s526n benchmark core into a WIDTH-bit signature over a programmed capture window, then compares it against an expected signature. Sits directly downstream of s526n in the self-test harness: its RESP bus is driven by {G214,G213,G199,G198,G148,G147} (MSB..LSB), sampled on the same CK as the core's flip-flops.

## Interface
- WIDTH, 6, signature/response width; must be ≥2.
- CNT_W, 16, capture-length counter width.
- POLY, 6'h03, feedback taps applied when the outgoing MSB is 1; the default is x^6+x+1.
- CK  in  1  rising-edge clock, shared with s526n.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin a capture; honoured only in IDLE or DONE.
- ABORT  in  1  cancel a capture; honoured only in RUN.
- LEN  in  CNT_W  number of RESP samples to compact; sampled with START.
- SEED  in  WIDTH  initial signature; sampled with START.
- EXPECT  in  WIDTH  golden signature; sampled with START.
- RESP  in  WIDTH  core response, s526n outputs.
- SIG  out  WIDTH  current signature.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle completion pulse.
- PASS  out  1  SIG==EXPECT at completion; held until the next START/ABORT/RST.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; no illegal state may be reachable.
- IDLE/DONE + START:
  - SIG←SEED, cnt←LEN, exp←EXPECT, PASS←0.
  - If LEN≠0 go to RUN. If LEN==0 go to DONE.
- RUN, each cycle:
  - SIG←{SIG[WIDTH-2:0],1'b0} ^ (SIG[WIDTH-1] ? POLY : 0) ^ RESP_eff.
  - cnt←cnt−1.
  - When cnt==1, the final sample is taken this cycle. Go to DONE.
- RUN + ABORT: go to IDLE with no compaction that cycle, PASS←0, no DONE pulse. ABORT has priority over the last-sample transition.
- Entry to DONE: PASS←(final SIG==exp). DONE=1 for exactly the DONE cycle. Next state is IDLE, or RUN/DONE if START is present.
- START in RUN is ignored. ABORT outside RUN is ignored.
- SIG holds in IDLE and DONE.
- Width rule: all arithmetic is GF(2) XOR, with no carries. LEN is unsigned; LEN=2^CNT_W−1 must complete.

## Timing
- Reset values: state IDLE, SIG=0, BUSY=0, DONE=0, PASS=0, cnt=0. Reset is effective immediately and asynchronously, including mid-RUN, with no DONE pulse.
- START sampled at edge k. RESP is sampled at edges k+1 … k+LEN.
- DONE and PASS are valid after edge k+LEN, with DONE high during cycle k+LEN..k+LEN+1. For LEN=0, DONE is high after edge k.
- BUSY is high after edges k … k+LEN−1.
- Back-to-back: START asserted during the DONE cycle restarts with no idle gap.
- All outputs are registered, with no combinational path from inputs.

## Configuration
- S526_MISR_XMASK_EN defined:
  - Adds port XMASK (in, WIDTH), sampled every RUN cycle.
  - RESP_eff = RESP & ~XMASK, which suppresses unknown or uninitialised core outputs.
- Not defined:
  - No XMASK port.
  - RESP_eff = RESP.

## Test plan
- Reset then START with SEED=0, LEN=1, RESP=6'h2A -> after 2 edges SIG=6'h2A, DONE pulse; with EXPECT=6'h2A PASS=1, with EXPECT=6'h2B PASS=0.
- SEED=0, LEN=2, RESP=6'h20 then 6'h00 -> SIG=6'h20 then 6'h03; DONE high exactly one cycle; BUSY high 2 cycles.
- LEN=0, SEED=6'h15, EXPECT=6'h15 -> DONE the cycle after START, SIG=6'h15, PASS=1, BUSY never high.
- LEN=10, ABORT at the 4th RUN cycle -> IDLE, BUSY=0, no DONE, PASS=0, SIG frozen at the 3-sample value. START asserted mid-RUN has no effect.
- RST pulsed mid-RUN, asynchronous with CK -> all outputs 0 immediately. A following START with LEN=3 completes normally.
- With S526_MISR_XMASK_EN: SEED=0, XMASK=6'h3F, LEN=8, random RESP -> SIG=0 at DONE. Without the macro, the same stimulus matches the reference-model signature.
